// File: rtl/myniosiicpu_cpu_oci_dct_pkg.sv
// Shared types and helpers for the OCI DCT trace capture buffer.
// State encodings and the entry-count width function.
package myniosiicpu_cpu_oci_dct_pkg;

  typedef logic [1:0] state_t;

  localparam state_t CAPTURE = 2'd0;
  localparam state_t DRAIN   = 2'd1;
  localparam state_t DONE    = 2'd2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/myniosiicpu_cpu_oci_dct_ram.sv
// Trace word storage: one registered write port, one async read port.
// Contents are never cleared; validity is tracked by the owner.
module myniosiicpu_cpu_oci_dct_ram #(
  parameter int DCT_W = 30,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DCT_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [DCT_W-1:0] rdata_o
);

  logic [DCT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/myniosiicpu_cpu_oci_dct_capture.sv
// Circular DCT trace capture buffer: capture, then drain oldest-first.
// Stop-when-full or keep-latest, selected per write by wrap_mode.
module myniosiicpu_cpu_oci_dct_capture
  import myniosiicpu_cpu_oci_dct_pkg::*;
#(
  parameter int DCT_W = 30,
  parameter int DEPTH = 16,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DCT_W-1:0] dct_buffer,
  input  logic             dct_valid,
  input  logic             wrap_mode,
  input  logic             test_ending,
  input  logic             rd_ready,
  output logic [DCT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] dct_count,
  output logic             overflow,
  output logic             test_has_ended
);

  localparam int AW = $clog2(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             full, cap, we, drop, xfer;
  logic [DCT_W-1:0] ram_rdata;

  myniosiicpu_cpu_oci_dct_ram #(
    .DCT_W (DCT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (dct_buffer),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CAPTURE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAPTURE: if (test_ending) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  always_comb begin
    rd_valid       = (state_q == DRAIN) && (count_q != '0);
    test_has_ended = (state_q == DONE);
    rd_data        = rd_valid ? ram_rdata : '0;
    dct_count      = count_q;
    overflow       = ovf_q;
  end

  // A full write in wrap mode evicts the oldest entry in the same cycle.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    cap      = (state_q == CAPTURE);
    we       = cap && dct_valid && (!full || wrap_mode);
    drop     = cap && dct_valid && full;
    xfer     = rd_valid && rd_ready;
    wr_ptr_d = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = (xfer || (we && full)) ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q || drop;
    count_d  = count_q;
    unique case (1'b1)
      we && !full: count_d = count_q + CNT_W'(1);
      xfer:        count_d = count_q - CNT_W'(1);
      default:     count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_myniosiicpu_cpu_oci_dct_capture.sv
// Scoreboard bench for the DCT capture buffer.
// Stimulus pushes expected drain words; a negedge monitor pops and compares.
module tb_myniosiicpu_cpu_oci_dct_capture;

  localparam int DCT_W = 30;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [DCT_W-1:0] dct_buffer;
  logic             dct_valid;
  logic             wrap_mode;
  logic             test_ending;
  logic             rd_ready;
  logic [DCT_W-1:0] rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] dct_count;
  logic             overflow;
  logic             test_has_ended;

  int checks   = 0;
  int failures = 0;

  logic [DCT_W-1:0] sb [$];
  logic             held_v = 1'b0;
  logic [DCT_W-1:0] held_d = '0;

  myniosiicpu_cpu_oci_dct_capture #(
    .DCT_W (DCT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_valid      (dct_valid),
    .wrap_mode      (wrap_mode),
    .test_ending    (test_ending),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      held_v <= 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_hold_valid", {31'd0, rd_valid}, 32'd1);
        chk("stall_hold_data", {2'd0, rd_data}, {2'd0, held_d});
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {2'd0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          chk("drain_data", {2'd0, rd_data}, {2'd0, sb.pop_front()});
        end
      end
      held_v <= rd_valid && !rd_ready;
      held_d <= rd_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dct_valid = 1'b0;
    test_ending = 1'b0;
    rd_ready = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wr(input logic [DCT_W-1:0] w);
    dct_valid = 1'b1;
    dct_buffer = w;
    step();
    dct_valid = 1'b0;
  endtask

  task automatic end_test();
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
  endtask

  task automatic wait_done(input string name);
    rd_ready = 1'b1;
    for (int i = 0; i < 100 && !test_has_ended; i++) step();
    chk({name, "_ended"}, {31'd0, test_has_ended}, 32'd1);
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    dct_buffer = '0;
    wrap_mode = 1'b0;
    do_reset();
    chk("rst_count", {27'd0, dct_count}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_data", {2'd0, rd_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ended", {31'd0, test_has_ended}, 32'd0);

    // 1: basic five words, back-to-back drain timing
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(DCT_W'(i));
      wr(DCT_W'(i));
    end
    chk("t1_count", {27'd0, dct_count}, 32'd5);
    rd_ready = 1'b1;
    end_test();
    repeat (5) step();
    chk("t1_count0", {27'd0, dct_count}, 32'd0);
    chk("t1_not_ended", {31'd0, test_has_ended}, 32'd0);
    step();
    chk("t1_ended", {31'd0, test_has_ended}, 32'd1);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    chk("t1_sb", sb.size(), 32'd0);
    chk("t1_done_valid", {31'd0, rd_valid}, 32'd0);

    // 2: stop-when-full
    do_reset();
    wrap_mode = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 16) sb.push_back(DCT_W'(i));
      wr(DCT_W'(i));
    end
    chk("t2_count", {27'd0, dct_count}, 32'd16);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    end_test();
    wait_done("t2");

    // 3: keep-latest
    do_reset();
    wrap_mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i >= 5) sb.push_back(DCT_W'(i));
      wr(DCT_W'(i));
    end
    chk("t3_count", {27'd0, dct_count}, 32'd16);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    end_test();
    wait_done("t3");
    wrap_mode = 1'b0;

    // 4: backpressure 1,0,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(DCT_W'(32'h10 + i));
      wr(DCT_W'(32'h10 + i));
    end
    end_test();
    chk("t4_valid", {31'd0, rd_valid}, 32'd1);
    rd_ready = 1'b1;
    step();
    chk("t4_cnt_a", {27'd0, dct_count}, 32'd3);
    rd_ready = 1'b0;
    step();
    step();
    chk("t4_cnt_b", {27'd0, dct_count}, 32'd3);
    rd_ready = 1'b1;
    step();
    chk("t4_cnt_c", {27'd0, dct_count}, 32'd2);
    wait_done("t4");

    // 5a: word captured in the test_ending cycle
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(DCT_W'(i));
      wr(DCT_W'(i));
    end
    sb.push_back(DCT_W'(32'hAB));
    dct_valid = 1'b1;
    dct_buffer = DCT_W'(32'hAB);
    test_ending = 1'b1;
    step();
    dct_valid = 1'b0;
    test_ending = 1'b0;
    chk("t5_count", {27'd0, dct_count}, 32'd4);
    wait_done("t5a");

    // 5b: empty buffer finishes two cycles after test_ending
    do_reset();
    rd_ready = 1'b1;
    end_test();
    chk("t5b_not_yet", {31'd0, test_has_ended}, 32'd0);
    chk("t5b_no_valid", {31'd0, rd_valid}, 32'd0);
    step();
    chk("t5b_ended", {31'd0, test_has_ended}, 32'd1);
    rd_ready = 1'b0;

    // 6: reset mid-drain
    do_reset();
    wrap_mode = 1'b1;
    for (int i = 1; i <= 18; i++) wr(DCT_W'(i));
    wrap_mode = 1'b0;
    chk("t6_ovf_set", {31'd0, overflow}, 32'd1);
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      sb.push_back(DCT_W'(32'h60 + i));
      wr(DCT_W'(32'h60 + i));
    end
    rd_ready = 1'b1;
    end_test();
    step();
    step();
    chk("t6_count_mid", {27'd0, dct_count}, 32'd4);
    chk("t6_sb_mid", sb.size(), 32'd4);
    reset = 1'b1;
    rd_ready = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
    chk("t6_count", {27'd0, dct_count}, 32'd0);
    chk("t6_valid", {31'd0, rd_valid}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_ended", {31'd0, test_has_ended}, 32'd0);
    sb.push_back(DCT_W'(32'h3FF_0001));
    wr(DCT_W'(32'h3FF_0001));
    sb.push_back(DCT_W'(32'h2AA_5555));
    wr(DCT_W'(32'h2AA_5555));
    chk("t6_fresh_count", {27'd0, dct_count}, 32'd2);
    end_test();
    wait_done("t6");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
